mem_arbiter: RTL and testbench

Two-port arbiter that shares the single LC-3b memory port between an instruction-fetch requester (port A) and a data-access requester (port B). Sits between the control/datapath and physical memory. Uses the same hold-until-`resp` handshake the control unit already uses, so either side connects without changes. A registered FSM grants one requester at a time and holds the grant until memory responds.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one LC-3b memory port between fetch (A) and data (B) requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default build gives port B fixed priority.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int MASK_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [MASK_W-1:0] a_byte_enable,
   output logic              a_resp,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [MASK_W-1:0] b_byte_enable,
   output logic              b_resp,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [MASK_W-1:0] mem_byte_enable,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
   typedef enum logic {PORT_A, PORT_B} port_t;

   state_t state_q, state_d;
   port_t  last_q, last_d;

   logic a_req, b_req;
   assign a_req = a_read | a_write;
   assign b_req = b_read | b_write;

   assign rdata = mem_rdata;

   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d = state_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (a_req && b_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               state_d = (last_q == PORT_A) ? GRANT_B : GRANT_A;
`else
               state_d = GRANT_B;
`endif
            end else if (a_req) begin
               state_d = GRANT_A;
            end else if (b_req) begin
               state_d = GRANT_B;
            end
         end
         GRANT_A: begin
            if (mem_resp) begin
               state_d = IDLE;
               last_d  = PORT_A;
            end
         end
         GRANT_B: begin
            if (mem_resp) begin
               state_d = IDLE;
               last_d  = PORT_B;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; the async reset also
   // drops the memory strobes immediately because they decode from state_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= PORT_B;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   // Write wins over read when the owner illegally asserts both.
   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_wdata       = '0;
      mem_byte_enable = '0;
      a_resp          = 1'b0;
      b_resp          = 1'b0;
      unique case (state_q)
         GRANT_A: begin
            mem_write       = a_write;
            mem_read        = a_read & ~a_write;
            mem_address     = a_address;
            mem_wdata       = a_wdata;
            mem_byte_enable = a_byte_enable;
            a_resp          = mem_resp;
         end
         GRANT_B: begin
            mem_write       = b_write;
            mem_read        = b_read & ~b_write;
            mem_address     = b_address;
            mem_wdata       = b_wdata;
            mem_byte_enable = b_byte_enable;
            b_resp          = mem_resp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a monitor pops and compares on every a_resp/b_resp.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        a_read, a_write, b_read, b_write;
   logic [15:0] a_address, a_wdata, b_address, b_wdata;
   logic [1:0]  a_byte_enable, b_byte_enable;
   logic        a_resp, b_resp;
   logic [15:0] rdata;
   logic        mem_read, mem_write;
   logic [15:0] mem_address, mem_wdata;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_rdata;
   logic        mem_resp;
   logic        resp_r, spur;

   int          checks = 0;
   int          errors = 0;
   int          lat;
   logic [15:0] rd_val;

   typedef struct {
      bit          port;
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] rdata;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   assign mem_resp = resp_r | spur;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MASK_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
      .a_byte_enable(a_byte_enable), .a_resp(a_resp),
      .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
      .b_byte_enable(b_byte_enable), .b_resp(b_resp),
      .rdata(rdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input bit port, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [1:0] be);
      exp_t e;
      e.port = port; e.wr = wr; e.addr = addr; e.wdata = wdata; e.be = be; e.rdata = rd_val;
      sb.push_back(e);
   endtask

   task automatic sync();
      @(posedge clk);
      #3;
   endtask

   // Memory model: responds in the lat-th cycle a strobe is held.
   int mcnt = 0;
   always begin
      @(posedge clk);
      #1;
      if (mem_read | mem_write) begin
         mcnt++;
         if (mcnt == lat) begin
            resp_r    = 1'b1;
            mem_rdata = rd_val;
         end else begin
            resp_r = 1'b0;
         end
      end else begin
         mcnt   = 0;
         resp_r = 1'b0;
      end
   end

   // Monitor: every completion must match the head of the scoreboard.
   always @(negedge clk) begin
      if (a_resp | b_resp) begin
         exp_t e;
         if (a_resp && b_resp) check("both_resp", 1, 0);
         if (sb.size() == 0) begin
            check("unexpected_resp", {a_resp, b_resp}, 0);
         end else begin
            e = sb.pop_front();
            check("resp_port", b_resp, e.port);
            check("mem_write", mem_write, e.wr);
            check("mem_read", mem_read, !e.wr);
            check("mem_address", mem_address, e.addr);
            check("mem_wdata", mem_wdata, e.wdata);
            check("mem_byte_enable", mem_byte_enable, e.be);
            check("rdata", rdata, e.rdata);
         end
      end
   end

   // Requester: raise a request, hold it until its resp, drop it after the resp edge.
   task automatic req(input bit port, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wdata, input logic [1:0] be);
      bit got = 0;
      if (!port) begin
         a_read = rd; a_write = wr; a_address = addr; a_wdata = wdata; a_byte_enable = be;
      end else begin
         b_read = rd; b_write = wr; b_address = addr; b_wdata = wdata; b_byte_enable = be;
      end
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (port ? b_resp : a_resp) begin
            got = 1;
            break;
         end
      end
      check("req_completed", got, 1);
      @(posedge clk);
      #3;
      if (!port) begin
         a_read = 0; a_write = 0;
      end else begin
         b_read = 0; b_write = 0;
      end
   endtask

   task automatic run_seq(input bit port, input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) req(port, 0, 1, base + 16'(i), ~(base + 16'(i)), 2'b11);
   endtask

   bit done_a, done_b;

   task automatic wait_done(input string name);
      for (int i = 0; i < 300; i++) begin
         if (done_a && done_b) break;
         @(negedge clk);
      end
      check(name, done_a & done_b, 1);
   endtask

   initial begin
      int cnt;
      bit got;
      rst_n = 0; spur = 0; resp_r = 0; lat = 3; rd_val = 16'h0000;
      a_read = 0; a_write = 0; a_address = 0; a_wdata = 0; a_byte_enable = 0;
      b_read = 0; b_write = 0; b_address = 0; b_wdata = 0; b_byte_enable = 0;
      mem_rdata = 16'h5A5A;

      #1;
      check("rst_mem_read", mem_read, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_resps", {a_resp, b_resp}, 0);
      check("rst_mem_address", mem_address, 0);
      check("rdata_passthru", rdata, 16'h5A5A);
      repeat (2) @(posedge clk);
      #3 rst_n = 1;

      // Single read from A, memory answers in the third cycle.
      sync();
      lat = 3; rd_val = 16'h1234;
      push(0, 0, 16'h0040, 16'h0000, 2'b11);
      a_read = 1; a_address = 16'h0040; a_wdata = 0; a_byte_enable = 2'b11;
      cnt = 0; got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_read) begin
            cnt++;
            check("rd_addr", mem_address, 16'h0040);
         end
         if (a_resp) begin
            got = 1;
            break;
         end
      end
      check("rd_cycles", cnt, 3);
      check("rd_done", got, 1);
      @(posedge clk);
      #3 a_read = 0;

      // Single write from B.
      lat = 2; rd_val = 16'h0000;
      push(1, 1, 16'h0100, 16'hBEEF, 2'b01);
      req(1, 0, 1, 16'h0100, 16'hBEEF, 2'b01);

      // Tie right after reset, minimum-length transactions.
      rst_n = 0;
      sync();
      rst_n = 1;
      lat = 1; rd_val = 16'h00AA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      push(0, 0, 16'h0A0A, 16'h0000, 2'b11);
      push(1, 1, 16'h0B0B, 16'h1111, 2'b11);
`else
      push(1, 1, 16'h0B0B, 16'h1111, 2'b11);
      push(0, 0, 16'h0A0A, 16'h0000, 2'b11);
`endif
      done_a = 0; done_b = 0;
      fork
         begin req(0, 1, 0, 16'h0A0A, 16'h0000, 2'b11); done_a = 1; end
         begin req(1, 0, 1, 16'h0B0B, 16'h1111, 2'b11); done_b = 1; end
      join_none
      @(negedge clk);
      check("tie_idle", mem_read | mem_write, 0);
      @(negedge clk);
      check("tie_grant_latency", mem_read | mem_write, 1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check("tie_first", mem_address, 16'h0A0A);
`else
      check("tie_first", mem_address, 16'h0B0B);
`endif
      @(negedge clk);
      check("tie_bubble", mem_read | mem_write, 0);
      @(negedge clk);
      check("tie_second", mem_read | mem_write, 1);
      wait_done("tie_done");

      // Continuous contention with back-to-back re-requests.
      sync();
      lat = 1; rd_val = 16'h0C0C;
      done_a = 0; done_b = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 3; i++) begin
         push(0, 1, 16'h2000 + 16'(i), ~(16'h2000 + 16'(i)), 2'b11);
         push(1, 1, 16'h3000 + 16'(i), ~(16'h3000 + 16'(i)), 2'b11);
      end
      fork
         begin run_seq(0, 3, 16'h2000); done_a = 1; end
         begin run_seq(1, 3, 16'h3000); done_b = 1; end
      join_none
`else
      for (int i = 0; i < 6; i++) push(1, 1, 16'h3000 + 16'(i), ~(16'h3000 + 16'(i)), 2'b11);
      push(0, 1, 16'h2000, ~16'h2000, 2'b11);
      fork
         begin run_seq(0, 1, 16'h2000); done_a = 1; end
         begin run_seq(1, 6, 16'h3000); done_b = 1; end
      join_none
`endif
      wait_done("contention_done");

      // Reset in the middle of a B write; a pending A read follows release.
      sync();
      lat = 10;
      b_write = 1; b_address = 16'h0200; b_wdata = 16'h7777; b_byte_enable = 2'b11;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_write) break;
      end
      check("abort_b_granted", mem_write, 1);
      #1;
      rst_n = 0;
      b_write = 0;
      a_read = 1; a_address = 16'h0300; a_wdata = 0; a_byte_enable = 2'b11;
      #1;
      check("abort_strobes_drop", {mem_read, mem_write}, 0);
      check("abort_resps", {a_resp, b_resp}, 0);
      @(posedge clk);
      #3;
      lat = 2; rd_val = 16'hCAFE;
      push(0, 0, 16'h0300, 16'h0000, 2'b11);
      rst_n = 1;
      @(negedge clk);
      check("post_rst_idle", mem_read | mem_write, 0);
      @(negedge clk);
      check("post_rst_grant", mem_read, 1);
      check("post_rst_addr", mem_address, 16'h0300);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (a_resp) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      check("post_rst_done", got, 1);
      @(posedge clk);
      #3 a_read = 0;

      // Illegal read+write from the owner: only the write reaches memory.
      lat = 2; rd_val = 16'h0000;
      push(0, 1, 16'h0400, 16'h0F0F, 2'b10);
      req(0, 1, 1, 16'h0400, 16'h0F0F, 2'b10);

      // Spurious mem_resp in IDLE.
      sync();
      spur = 1;
      @(negedge clk);
      check("spur_resps", {a_resp, b_resp}, 0);
      check("spur_strobes", mem_read | mem_write, 0);
      @(posedge clk);
      #3 spur = 0;
      @(negedge clk);
      check("spur_still_idle", mem_read | mem_write, 0);

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
